memctrl: RTL
============

// Module: memctrl
// PURPOSE
// - Responder side of the mem_get/mem_wr/mem_len/mem_done request protocol. Serves the MEM
//   stage (loads, stores, dcache write-backs/refills) and the IF stage (4-byte fetches).
// - Serializes each request onto the byte-wide RAM/IO port.
// - Sits between the pipeline stages and the external ram/io bus; MEM has priority over IF.
// PARAMETERS
// ADDR_W   32        address width of all address ports
// IO_HI    2'b11     value of addr[17:16] that selects the I/O region (0x30000+)
// PORTS
// clk_in          in   1       clock
// rst_in          in   1       synchronous active-high reset
// rdy_in          in   1       global ready; 0 freezes all state
// mem_get         in   1       MEM request valid (held by requester until mem_done)
// mem_wr          in   1       MEM request is a write
// mem_address     in   ADDR_W  MEM byte address
// mem_data        in   32      MEM write data, little-endian, low bytes used
// mem_len         in   3       MEM byte count: 1, 2 or 4
// mem_done        out  1       one-cycle completion pulse to MEM
// mem_out         out  32      MEM read data, zero-extended beyond mem_len
// if_get          in   1       IF fetch request valid (always 4 bytes, read-only)
// if_address      in   ADDR_W  IF fetch address
// if_done         out  1       one-cycle completion pulse to IF
// if_out          out  32      fetched instruction word
// ram_din         in   8       byte returned by RAM/IO, one cycle after its address
// ram_dout        out  8       byte to write
// ram_a           out  ADDR_W  byte address to RAM/IO
// ram_wr          out  1       1 = write ram_dout at ram_a this cycle
// io_buffer_full  in   1       I/O write buffer full; I/O writes must wait
// BEHAVIOUR
// - Reset (rst_in=1 at posedge): state=IDLE, cnt=0. All outputs 0, including mem_out/if_out.
// - rdy_in=0: no state, counter or output register changes; ram_wr forced 0.
//   Work resumes exactly where it stopped.
// - States: IDLE, READ, WRITE.
// - IDLE accept rule:
//   - Accept only when mem_done=0 and if_done=0, so stale requests in a done cycle are ignored.
//   - mem_get=1 wins: latch address, data, len, wr, src=MEM.
//   - Else if_get=1: latch if_address, len=4, wr=0, src=IF.
//   - Then go to READ or WRITE with cnt=0.
//   - Requests are sampled only at accept; later input changes are ignored.
// - IDLE outputs: ram_a=0, ram_wr=0.
// - READ, len L:
//   - Cycle k (k=0..L-1) drives ram_a = addr+k, ram_wr=0.
//   - Byte k is captured from ram_din in cycle k+1 into buffer bits [8k+7:8k].
//   - After the cycle that captures byte L-1 (L+1 cycles in READ), go to IDLE.
//   - On entering IDLE, load the buffer (upper bytes 0) into mem_out or if_out and pulse the
//     matching done for exactly one cycle.
//   - Latency: accept at edge t gives done high in cycle t+L+1 (LW: 5 cycles after accept).
// - WRITE, len L:
//   - Cycle k drives ram_a = addr+k, ram_dout = data[8k+7:8k], ram_wr=1.
//   - If addr[17:16]==IO_HI and io_buffer_full=1, that cycle drives ram_wr=0 and holds cnt.
//   - After byte L-1 is written, go to IDLE and pulse mem_done one cycle. mem_out is unchanged.
// - Address arithmetic: addr+k is ADDR_W-bit modular.
// - Writes always come from MEM, never from IF.
// - mem_out/if_out hold their value until the next completion of the same source.
// - Simultaneous mem_get and if_get in IDLE: only MEM is served. IF stays pending and is
//   accepted at the next eligible IDLE cycle if still asserted.
// - Reset mid-transaction aborts it immediately: no done pulse, ram_wr=0 next cycle.
// - mem_len=0 or other unsupported values are treated as 4.
// TESTING
// 1. MEM LW at 0x100, RAM 0x100..0x103 = 11 22 33 44.
//    -> ram_a 0x100..0x103 on consecutive cycles; mem_done one cycle; mem_out=0x44332211.
// 2. MEM SB 0x204 data 0xAABBCCDD, then SH 0x206 data 0x1234.
//    -> one write of DD at 0x204; then 34@0x206 and 12@0x207; each followed by one mem_done.
// 3. mem_get (LB 0x10) and if_get (0x0) asserted together.
//    -> LB served first with mem_out=zero-ext byte; IF accepted next; if_done with if_out=word@0x0.
// 4. SW to 0x30000 data 0x41, io_buffer_full=1 for 3 cycles at byte 0.
//    -> ram_wr=0 for those 3 cycles; then bytes 41,00,00,00 written; mem_done after byte 3.
// 5. rdy_in=0 for 4 cycles during LW byte 2.
//    -> ram_wr=0, state frozen; final mem_out is still correct; done appears 4 cycles later.
// 6. rst_in=1 during SW byte 1.
//    -> next cycle ram_wr=0, all outputs 0, no mem_done; a new request after reset completes normally.

Source files
------------

// File: rtl/memctrl.sv
// Byte-serial responder for the MEM/IF request protocol in front of the RAM/IO port.
// MEM has priority over IF; every transfer walks one byte per cycle.
module memctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              mem_get,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_data,
  input  logic [2:0]        mem_len,
  output logic              mem_done,
  output logic [31:0]       mem_out,
  input  logic              if_get,
  input  logic [ADDR_W-1:0] if_address,
  output logic              if_done,
  output logic [31:0]       if_out,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d, buf_q, buf_d;
  logic [31:0]       mem_out_q, mem_out_d, if_out_q, if_out_d;
  logic              src_mem_q, src_mem_d;
  logic              mem_done_q, mem_done_d, if_done_q, if_done_d;
  logic              io_stall;
  logic [1:0]        rd_byte;
  logic [2:0]        len_norm;

  assign io_stall = (addr_q[17:16] == IO_HI) && io_buffer_full;
  assign rd_byte  = cnt_q[1:0] - 2'd1;
  assign len_norm = (mem_len == 3'd1 || mem_len == 3'd2) ? mem_len : 3'd4;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      buf_q      <= '0;
      mem_out_q  <= '0;
      if_out_q   <= '0;
      src_mem_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      buf_q      <= buf_d;
      mem_out_q  <= mem_out_d;
      if_out_q   <= if_out_d;
      src_mem_q  <= src_mem_d;
      mem_done_q <= mem_done_d;
      if_done_q  <= if_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    buf_d      = buf_q;
    mem_out_d  = mem_out_q;
    if_out_d   = if_out_q;
    src_mem_d  = src_mem_q;
    mem_done_d = 1'b0;
    if_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A request still high during its own done cycle is stale.
        if (!mem_done_q && !if_done_q) begin
          if (mem_get) begin
            addr_d    = mem_address;
            data_d    = mem_data;
            len_d     = len_norm;
            src_mem_d = 1'b1;
            cnt_d     = '0;
            buf_d     = '0;
            state_d   = mem_wr ? S_WRITE : S_READ;
          end else if (if_get) begin
            addr_d    = if_address;
            len_d     = 3'd4;
            src_mem_d = 1'b0;
            cnt_d     = '0;
            buf_d     = '0;
            state_d   = S_READ;
          end
        end
      end
      S_READ: begin
        if (cnt_q != 3'd0) buf_d[{rd_byte, 3'b000} +: 8] = ram_din;
        if (cnt_q == len_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (src_mem_q) begin
            mem_out_d  = buf_d;
            mem_done_d = 1'b1;
          end else begin
            if_out_d  = buf_d;
            if_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WRITE: begin
        if (!io_stall) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            mem_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    case (state_q)
      S_READ: begin
        // While frozen, re-present the previous byte address so ram_din still
        // carries the byte awaiting capture when work resumes.
        if (!rdy_in && cnt_q != 3'd0) ram_a = addr_q + ADDR_W'(cnt_q - 3'd1);
        else                          ram_a = addr_q + ADDR_W'(cnt_q);
      end
      S_WRITE: begin
        ram_a    = addr_q + ADDR_W'(cnt_q);
        ram_dout = data_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr   = rdy_in && !io_stall;
      end
      default: ;
    endcase
  end

  assign mem_done = mem_done_q;
  assign if_done  = if_done_q;
  assign mem_out  = mem_out_q;
  assign if_out   = if_out_q;

endmodule
